// File: rtl/disp_mux_7seg.sv
// disp_mux_7seg: time-multiplexes the units and tens 7-segment patterns onto
// a shared active-low cathode bus, one anode at a time, with blank gap phases
// between digits and a one-cycle frame_tick at the end of each refresh frame.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks the tens digit when its
// captured pattern is '0'.
// There is no valid/ready handshake: the segment inputs are sampled only on
// the edge that enters the matching SHOW state, and the outputs are refreshed
// every clock. state_dbg exposes the FSM state (0=SHOW_U,1=GAP_U,2=SHOW_T,
// 3=GAP_T) for checkers.
module disp_mux_7seg #(
  parameter int DIGIT_CYCLES = 100_000,
  parameter int GAP_CYCLES   = 1_000
) (
  input  logic       reloj,
  input  logic       rst_n,
  input  logic [6:0] segU_in,
  input  logic [6:0] segD_in,
  output logic [6:0] seg_out,
  output logic [3:0] an_out,
  output logic       dp_out,
  output logic       frame_tick,
  output logic [1:0] state_dbg
);

  localparam int MAX_LEN = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] D_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic TENS_BLANK_EN = 1'b1;
`else
  localparam logic TENS_BLANK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    SHOW_U = 2'd0,
    GAP_U  = 2'd1,
    SHOW_T = 2'd2,
    GAP_T  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0]    hold, hold_n;
  logic          boot, boot_n;
  logic [6:0]    seg_n;
  logic [3:0]    an_n;
  logic          tick_n;

  // Next-state, next-counter and next-output decode; outputs are then
  // registered so they reflect the state being entered on the same edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    hold_n  = hold;
    seg_n   = SEG_OFF;
    an_n    = 4'b1111;
    tick_n  = 1'b0;

    case (state)
      SHOW_U: begin
        if (cnt == D_LAST) begin
          cnt_n = '0;
          if (GAP_CYCLES == 0) begin
            state_n = SHOW_T;
            hold_n  = segD_in;
          end else begin
            state_n = GAP_U;
          end
        end
      end
      GAP_U: begin
        if (cnt == G_LAST) begin
          cnt_n   = '0;
          state_n = SHOW_T;
          hold_n  = segD_in;
        end
      end
      SHOW_T: begin
        if (cnt == D_LAST) begin
          cnt_n = '0;
          if (GAP_CYCLES == 0) begin
            state_n = SHOW_U;
            hold_n  = segU_in;
          end else begin
            state_n = GAP_T;
          end
        end
      end
      default: begin
        if ((GAP_CYCLES == 0) || (cnt == G_LAST)) begin
          cnt_n   = '0;
          state_n = SHOW_U;
          hold_n  = segU_in;
        end
      end
    endcase

    // The blank phase straight out of reset is not a frame end.
    boot_n = boot && (state_n != SHOW_U);

    case (state_n)
      SHOW_U: begin
        an_n  = 4'b1110;
        seg_n = hold_n;
      end
      SHOW_T: begin
        if (!(TENS_BLANK_EN && (hold_n == SEG_ZERO))) begin
          an_n  = 4'b1101;
          seg_n = hold_n;
        end
      end
      default: begin
        an_n  = 4'b1111;
        seg_n = SEG_OFF;
      end
    endcase

    if (GAP_CYCLES == 0) begin
      tick_n = (state_n == SHOW_T) && (cnt_n == D_LAST);
    end else begin
      tick_n = (state_n == GAP_T) && (cnt_n == G_LAST) && !boot_n;
    end
  end

  // State, phase counter, hold register and registered outputs.
  always_ff @(posedge reloj or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GAP_T;
      cnt        <= '0;
      hold       <= SEG_OFF;
      boot       <= 1'b1;
      seg_out    <= SEG_OFF;
      an_out     <= 4'b1111;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hold       <= hold_n;
      boot       <= boot_n;
      seg_out    <= seg_n;
      an_out     <= an_n;
      frame_tick <= tick_n;
    end
  end

  assign dp_out    = 1'b1;
  assign state_dbg = state;

endmodule

// File: tb/tb_disp_mux_7seg.sv
// tb_disp_mux_7seg: directed scoreboard bench for disp_mux_7seg.
// Two instances share inputs and reset: main (DIGIT=4, GAP=2) and g0
// (DIGIT=4, GAP=0). Expected per-cycle {an, seg, frame_tick} words are pushed
// into one queue per instance; a monitor pops and compares on every falling
// edge while enabled.
module tb_disp_mux_7seg;

  localparam int W = 12;

  localparam logic [6:0] P1  = 7'b1111001; // '1'
  localparam logic [6:0] P2  = 7'b0100100; // '2'
  localparam logic [6:0] P3  = 7'b0110000; // '3'
  localparam logic [6:0] P0  = 7'b1000000; // '0'
  localparam logic [6:0] OFF = 7'h7F;

  logic       reloj;
  logic       rst_n;
  logic [6:0] seg_u;
  logic [6:0] seg_d;

  logic [6:0] seg_out, seg_out0;
  logic [3:0] an_out, an_out0;
  logic       dp_out, dp_out0;
  logic       frame_tick, frame_tick0;
  logic [1:0] state_dbg, state_dbg0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp0_q[$];

  int  checks;
  int  errors;
  bit  mon_en;
  int  smp;

  disp_mux_7seg #(.DIGIT_CYCLES(4), .GAP_CYCLES(2)) u_dut (
    .reloj(reloj), .rst_n(rst_n), .segU_in(seg_u), .segD_in(seg_d),
    .seg_out(seg_out), .an_out(an_out), .dp_out(dp_out),
    .frame_tick(frame_tick), .state_dbg(state_dbg)
  );

  disp_mux_7seg #(.DIGIT_CYCLES(4), .GAP_CYCLES(0)) u_dut0 (
    .reloj(reloj), .rst_n(rst_n), .segU_in(seg_u), .segD_in(seg_d),
    .seg_out(seg_out0), .an_out(an_out0), .dp_out(dp_out0),
    .frame_tick(frame_tick0), .state_dbg(state_dbg0)
  );

  // Clock / reset
  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  function automatic logic [W-1:0] w_of(logic [3:0] an, logic [6:0] seg, logic ft);
    return {an, seg, ft};
  endfunction

  function automatic logic [W-1:0] tens_w(logic [6:0] d, logic ft);
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 7'b1000000) return w_of(4'b1111, 7'h7F, ft);
`endif
    return w_of(4'b1101, d, ft);
  endfunction

  // Driver tasks: push expected cycles
  task automatic push_frame_main(input logic [6:0] u, input logic [6:0] d);
    repeat (4) exp_q.push_back(w_of(4'b1110, u, 1'b0));
    repeat (2) exp_q.push_back(w_of(4'b1111, OFF, 1'b0));
    repeat (4) exp_q.push_back(tens_w(d, 1'b0));
    exp_q.push_back(w_of(4'b1111, OFF, 1'b0));
    exp_q.push_back(w_of(4'b1111, OFF, 1'b1));
  endtask

  task automatic push_frame_g0(input logic [6:0] u, input logic [6:0] d);
    repeat (4) exp0_q.push_back(w_of(4'b1110, u, 1'b0));
    repeat (3) exp0_q.push_back(tens_w(d, 1'b0));
    exp0_q.push_back(tens_w(d, 1'b1));
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_main_seg"}, {9'd0, seg_out}, {9'd0, OFF});
    chk({tag, "_main_an"}, {12'd0, an_out}, 16'h000F);
    chk({tag, "_main_dp"}, {15'd0, dp_out}, 16'h0001);
    chk({tag, "_main_ft"}, {15'd0, frame_tick}, 16'h0000);
    chk({tag, "_g0_seg"}, {9'd0, seg_out0}, {9'd0, OFF});
    chk({tag, "_g0_an"}, {12'd0, an_out0}, 16'h000F);
    chk({tag, "_g0_dp"}, {15'd0, dp_out0}, 16'h0001);
    chk({tag, "_g0_ft"}, {15'd0, frame_tick0}, 16'h0000);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge reloj);
      if (exp_q.size() == 0 && exp0_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    mon_en = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: left main=%0d g0=%0d want 0", tag, exp_q.size(), exp0_q.size());
      exp_q.delete();
      exp0_q.delete();
    end
  endtask

  // Scoreboard monitor: one expected word per instance per cycle
  always @(negedge reloj) begin
    logic [W-1:0] w;
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL main_underflow: sample %0d got output with empty queue", smp);
      end else begin
        w = exp_q.pop_front();
        if ({an_out, seg_out, frame_tick} !== w) begin
          errors++;
          $display("FAIL main_out sample %0d: got an=%b seg=%b ft=%b want an=%b seg=%b ft=%b",
                   smp, an_out, seg_out, frame_tick, w[11:8], w[7:1], w[0]);
        end
      end
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL g0_underflow: sample %0d got output with empty queue", smp);
      end else begin
        w = exp0_q.pop_front();
        if ({an_out0, seg_out0, frame_tick0} !== w) begin
          errors++;
          $display("FAIL g0_out sample %0d: got an=%b seg=%b ft=%b want an=%b seg=%b ft=%b",
                   smp, an_out0, seg_out0, frame_tick0, w[11:8], w[7:1], w[0]);
        end
      end
      smp++;
    end
  end

  // Stimulus
  initial begin
    bit found;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    smp    = 0;
    rst_n  = 1'b0;
    seg_u  = P1;
    seg_d  = P2;

    // Reset state held across several edges
    repeat (3) @(posedge reloj);
    @(negedge reloj);
    check_idle("reset");
    chk("reset_state", {14'd0, state_dbg}, 16'h0003);

    // Release: steady frames, then an input-hold change mid SHOW_U
    exp_q.push_back(w_of(4'b1111, OFF, 1'b0));
    push_frame_main(P1, P2);
    push_frame_main(P1, P2);
    push_frame_main(P3, P2);
    repeat (2) push_frame_g0(P1, P2);
    repeat (2) push_frame_g0(P3, P2);
    repeat (4) exp0_q.push_back(w_of(4'b1110, P3, 1'b0));
    exp0_q.push_back(tens_w(P2, 1'b0));
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (15) @(negedge reloj);
    #1 seg_u = P3;
    drain("steady");

    // Async reset in the middle of SHOW_T
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge reloj);
      #1;
      if (an_out == 4'b1101) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL find_show_t: got no an=1101 within 50 cycles want one");
    end
    #2 rst_n = 1'b0;
    #1 check_idle("async");
    seg_d = P0;
    repeat (2) @(posedge reloj);
    @(negedge reloj);
    check_idle("async_hold");

    // Restart with a '0' tens pattern
    smp = 0;
    exp_q.push_back(w_of(4'b1111, OFF, 1'b0));
    push_frame_main(P3, P0);
    push_frame_g0(P3, P0);
    repeat (4) exp0_q.push_back(w_of(4'b1110, P3, 1'b0));
    exp0_q.push_back(tens_w(P0, 1'b0));
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drain("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
